// File: rtl/rf_wr_arb.sv
// Write-port arbiter for the 32x32 register file: round-robin between the ALU (0) and
// load (1) write-back paths, registered commit with $0 suppression, and write forwarding.
module rf_wr_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   input  logic        hold,
   input  logic [4:0]  r1_addr,
   input  logic [4:0]  r2_addr,
   output logic        RegWrite_en,
   output logic [4:0]  w_addr,
   output logic [31:0] w_data,
   output logic        r1_fwd_hit,
   output logic        r2_fwd_hit,
   output logic [31:0] r1_fwd_data,
   output logic [31:0] r2_fwd_data,
   output logic [15:0] wr_cnt
);

   logic        last_gnt_q, last_gnt_d;
   logic        we_q, we_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [15:0] cnt_q, cnt_d;
   logic        gnt0, gnt1;

   // Contested grant goes to the requester that did not win last time.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!hold) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_gnt_q;
            gnt1 = ~last_gnt_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      last_gnt_d = last_gnt_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      if (gnt0) begin
         last_gnt_d = 1'b0;
         addr_d     = req0_addr;
         data_d     = req0_data;
         we_d       = (req0_addr != 5'd0);
      end else if (gnt1) begin
         last_gnt_d = 1'b1;
         addr_d     = req1_addr;
         data_d     = req1_data;
         we_d       = (req1_addr != 5'd0);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (we_q && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= 5'd0;
         data_q     <= 32'd0;
         cnt_q      <= 16'd0;
      end else begin
         last_gnt_q <= last_gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
      end
   end

   assign RegWrite_en = we_q;
   assign w_addr      = addr_q;
   assign w_data      = data_q;
   assign wr_cnt      = cnt_q;

   // we_q is never set for $0, so no hit can occur on address 0.
   assign r1_fwd_hit  = we_q && (addr_q == r1_addr);
   assign r2_fwd_hit  = we_q && (addr_q == r2_addr);
   assign r1_fwd_data = data_q;
   assign r2_fwd_data = data_q;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_rf_wr_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0;
   logic [4:0]  req0_addr = '0;
   logic [31:0] req0_data = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [4:0]  req1_addr = '0;
   logic [31:0] req1_data = '0;
   logic        req1_ready;
   logic        hold = 1'b0;
   logic [4:0]  r1_addr = '0;
   logic [4:0]  r2_addr = '0;
   logic        RegWrite_en;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        r1_fwd_hit, r2_fwd_hit;
   logic [31:0] r1_fwd_data, r2_fwd_data;
   logic [15:0] wr_cnt;

   rf_wr_arb dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .req1_ready  (req1_ready),
      .hold        (hold),
      .r1_addr     (r1_addr),
      .r2_addr     (r2_addr),
      .RegWrite_en (RegWrite_en),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .r1_fwd_hit  (r1_fwd_hit),
      .r2_fwd_hit  (r2_fwd_hit),
      .r1_fwd_data (r1_fwd_data),
      .r2_fwd_data (r2_fwd_data),
      .wr_cnt      (wr_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the pending commit (if any), who won last, and the commit count.
   int          m_last;
   bit          m_we;
   bit [4:0]    m_addr;
   bit [31:0]   m_data;
   int unsigned m_cnt;
   int          m_gnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_last = 1;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_cnt  = 0;
      m_gnt  = -1;
   endtask

   // Who the arbiter should grant this cycle: -1 none, else requester index.
   function automatic int pick();
      if (hold) return -1;
      if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   task automatic check_all();
      int g;
      g = pick();
      check("ready0", 32'(req0_ready), 32'(g == 0));
      check("ready1", 32'(req1_ready), 32'(g == 1));
      check("we", 32'(RegWrite_en), 32'(m_we));
      check("w_addr", 32'(w_addr), 32'(m_addr));
      check("w_data", w_data, m_data);
      check("r1_hit", 32'(r1_fwd_hit), 32'(m_we && (m_addr == r1_addr)));
      check("r2_hit", 32'(r2_fwd_hit), 32'(m_we && (m_addr == r2_addr)));
      check("r1_fdata", r1_fwd_data, m_data);
      check("r2_fdata", r2_fwd_data, m_data);
      check("wr_cnt", 32'(wr_cnt), m_cnt);
   endtask

   task automatic model_edge(input int g);
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_we && m_cnt < 32'hFFFF) m_cnt++;
      m_gnt = g;
      if (g == 0) begin
         m_last = 0;
         m_addr = req0_addr;
         m_data = req0_data;
         m_we   = (req0_addr != 0);
      end else if (g == 1) begin
         m_last = 1;
         m_addr = req1_addr;
         m_data = req1_data;
         m_we   = (req1_addr != 0);
      end else begin
         m_we = 1'b0;
      end
   endtask

   // Inputs are set by the caller shortly after a posedge; returns 1 time unit after the next.
   task automatic step(input bit do_check);
      int g;
      @(negedge clk);
      if (do_check) check_all();
      g = pick();
      @(posedge clk);
      model_edge(g);
      #1;
   endtask

   task automatic idle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      hold       = 1'b0;
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
   endtask

   initial begin
      model_reset();
      step(1'b1);
      check("rst_we", 32'(RegWrite_en), 32'd0);
      check("rst_cnt", 32'(wr_cnt), 32'd0);
      rst_n = 1'b1;

      // Mid-stream reset drops the pending commit at once.
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h1111_0007;
      step(1'b1);
      step(1'b1);
      idle();
      async_reset();
      check("rst_async_we", 32'(RegWrite_en), 32'd0);
      check("rst_async_cnt", 32'(wr_cnt), 32'd0);
      step(1'b1);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h5;
      req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h6;
      #1;
      check("rst_first_gnt", 32'(req0_ready), 32'd1);
      step(1'b1);
      check("rst_waddr", 32'(w_addr), 32'd5);
      idle();
      step(1'b1);
      step(1'b1);

      // Single requester.
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hDEAD_BEEF;
      #1;
      check("single_ready", 32'(req1_ready), 32'd1);
      step(1'b1);
      idle();
      check("single_we", 32'(RegWrite_en), 32'd1);
      check("single_addr", 32'(w_addr), 32'd9);
      check("single_data", w_data, 32'hDEAD_BEEF);
      step(1'b1);
      check("single_we_off", 32'(RegWrite_en), 32'd0);

      // Fairness from a fresh reset.
      async_reset();
      step(1'b1);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA0;
      req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'hB0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("fair_gnt1", 32'(req1_ready), 32'(i % 2));
         step(1'b1);
         if (i % 2 == 0) begin
            req0_addr = req0_addr + 5'd1; req0_data = req0_data + 32'd1;
         end else begin
            req1_addr = req1_addr + 5'd1; req1_data = req1_data + 32'd1;
         end
      end
      idle();
      step(1'b1);
      check("fair_cnt", 32'(wr_cnt), 32'd6);

      // Writes to $0 are consumed but never committed.
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234; r1_addr = 5'd0;
      #1;
      check("zero_ready", 32'(req0_ready), 32'd1);
      step(1'b1);
      idle();
      check("zero_we", 32'(RegWrite_en), 32'd0);
      check("zero_hit", 32'(r1_fwd_hit), 32'd0);
      step(1'b1);
      check("zero_cnt", 32'(wr_cnt), 32'd6);

      // Forwarding of the in-flight write.
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA5A5_A5A5;
      step(1'b1);
      idle();
      r1_addr = 5'd3; r2_addr = 5'd4;
      #1;
      check("fwd_hit1", 32'(r1_fwd_hit), 32'd1);
      check("fwd_data1", r1_fwd_data, 32'hA5A5_A5A5);
      check("fwd_hit2", 32'(r2_fwd_hit), 32'd0);
      step(1'b1);
      check("fwd_hit1_off", 32'(r1_fwd_hit), 32'd0);

      // A req1 win first, so requester 0 wins the contest after hold.
      req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h0B;
      step(1'b1);
      req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h0C;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("hold_ready0", 32'(req0_ready), 32'd0);
         check("hold_ready1", 32'(req1_ready), 32'd0);
         step(1'b1);
         if (i > 0) check("hold_we", 32'(RegWrite_en), 32'd0);
      end
      hold = 1'b0;
      #1;
      check("hold_rel_gnt0", 32'(req0_ready), 32'd1);
      step(1'b1);
      idle();
      step(1'b1);

      // Randomized traffic; a waiting requester keeps its request stable.
      for (int i = 0; i < 3000; i++) begin
         if (!(req0_valid && m_gnt != 0)) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            req0_data  = $urandom;
         end
         if (!(req1_valid && m_gnt != 1)) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            req1_data  = $urandom;
         end
         hold    = ($urandom_range(0, 7) == 0);
         r1_addr = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom);
         r2_addr = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) async_reset();
         step(1'b1);
      end
      rst_n = 1'b1;
      idle();
      step(1'b1);

      // Saturation of the commit counter.
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h77;
      for (int i = 0; i < 70000 && m_cnt != 32'hFFFE; i++) step(1'b0);
      check("sat_pre", 32'(wr_cnt), 32'hFFFE);
      for (int i = 0; i < 3; i++) step(1'b1);
      idle();
      step(1'b1);
      step(1'b1);
      check("sat_cnt", 32'(wr_cnt), 32'hFFFF);
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h88;
      step(1'b1);
      idle();
      step(1'b1);
      step(1'b1);
      check("sat_hold", 32'(wr_cnt), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_wr_arb.md
# rf_wr_arb

Write-port arbiter for the 32x32 two-read/one-write register file. It shares the file's single write port between two write-back requesters, the ALU path (0) and the load path (1), using a valid/ready handshake with round-robin fairness. It drives the file's write-enable, address and data from registers, suppresses writes to $0, and forwards the in-flight write to both read ports.

## Interface
- No parameters. Data width is 32, address width is 5 and the file depth is 32.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU requester has a write.
- req0_addr  in  5  ALU destination register.
- req0_data  in  32  ALU result.
- req0_ready  out  1  combinational grant to requester 0.
- req1_valid, req1_addr, req1_data, req1_ready  as above, for the load requester.
- hold  in  1  debug halt; blocks all grants.
- r1_addr, r2_addr  in  5  current read addresses presented to the file.
- RegWrite_en  out  1  registered write enable to the file.
- w_addr  out  5  registered write address.
- w_data  out  32  registered write data.
- r1_fwd_hit, r2_fwd_hit  out  1  the in-flight write matches the read address.
- r1_fwd_data, r2_fwd_data  out  32  forwarded data; equals w_data.
- wr_cnt  out  16  count of committed writes; saturates.

## Operation
- **Grant, combinational:**
  - If hold=1, neither requester is ready.
  - If exactly one valid is high, that requester is ready.
  - If both are valid, the requester not named by last_gnt is ready.
  - A transfer occurs when a requester's valid and ready are both high at a posedge.
- **last_gnt (1-bit state):** set to the granted index on every transfer, contested or not.
- **Commit register:** on a transfer, w_addr and w_data load the granted addr and data.
  - RegWrite_en loads 1 when the granted addr≠0.
  - RegWrite_en loads 0 when addr=0. The request is still consumed.
  - With no transfer, RegWrite_en loads 0. w_addr and w_data hold their values.
- **Forwarding, combinational:** rN_fwd_hit = RegWrite_en & (w_addr==rN_addr). rN_fwd_data = w_data at all times.
  - The consumer selects fwd_data over the file output when hit=1.
  - Because of the $0 rule, a hit never occurs for address 0.
- **wr_cnt:** increments by 1 on each posedge where RegWrite_en=1. It holds at 0xFFFF once reached and never wraps.
- **Requester rules:** requesters keep addr and data stable while valid is high and ready is low. The block does not check this.

## Timing
- **Reset values:**
  - RegWrite_en=0, w_addr=0, w_data=0, wr_cnt=0.
  - last_gnt=1, so requester 0 wins the first contest.
  - Forward hits are 0, because RegWrite_en=0.
  - req*_ready follow their combinational rule even during reset. They are ignored until rst_n deasserts.
- **Latency:**
  - Transfer at edge T: RegWrite_en is high during cycle T..T+1.
  - The file captures the value at edge T+1.
  - A read issued in cycle T..T+1 gets the value via forwarding. A read at T+1 onward gets it from the file.
- **Throughput:** one write per cycle. Back-to-back transfers keep RegWrite_en high continuously with new addr and data each cycle.
- **Contention:** with both requesters valid continuously, grants alternate 0,1,0,1…; the losing requester waits at most one cycle.
- **Hold:** hold=1 at edge T means no transfer at T. A commit accepted at T-1 still completes, with RegWrite_en high in T-1..T. hold does not cancel an accepted write.
- **Reset mid-operation:** rst_n low clears RegWrite_en immediately (asynchronous), so a pending commit is dropped. last_gnt returns to 1.
- **Same address, back-to-back:** two transfers to the same address at T and T+1 must commit in order. The forward output reflects the newest value each cycle.

## Test plan
- **Reset:** drive rst_n=0 mid-stream → RegWrite_en=0 and wr_cnt=0 immediately. After release, both valid with addr 5 and 6 → req0 is granted first, and w_addr=5 next cycle.
- **Single requester:** req1 only, addr=9, data=0xDEADBEEF for one cycle → req1_ready=1. Next cycle RegWrite_en=1, w_addr=9, w_data=0xDEADBEEF. The following cycle RegWrite_en=0.
- **Fairness:** both valid for 6 cycles with distinct addresses → grant sequence 0,1,0,1,0,1, six commits, wr_cnt=6.
- **$0 suppression:** req0 addr=0, data=0x1234 → req0_ready=1, RegWrite_en stays 0, wr_cnt unchanged. r1_addr=0 gives r1_fwd_hit=0.
- **Forwarding:** commit addr=3, data=0xA5A5A5A5 with r1_addr=3, r2_addr=4 in the commit cycle → r1_fwd_hit=1 with data 0xA5A5A5A5, r2_fwd_hit=0. Next cycle r1_fwd_hit=0.
- **Hold and saturation:**
  - Assert hold with both requesters valid for 3 cycles → both ready=0 and no commits. Release → requester 0 is granted.
  - Preload traffic until wr_cnt=0xFFFE, then 3 more commits → wr_cnt=0xFFFF.
